// File: rtl/fechadura_mode_ctrl.sv
// Lock mode controller: shares the keypad stream and display bus between the
// operational and setup blocks, sequences setup entry/exit and owns the active config.
module fechadura_mode_ctrl #(
  parameter int SETUP_ON_CYC = 2,
  parameter int TIMEOUT_CYC  = 5000,
  parameter int SENHA_W      = 4,
  parameter int BCD_W        = 24,
  parameter int CFG_W        = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SENHA_W-1:0] key_value,
  input  logic               key_valid,
  input  logic               setup_req,
  output logic [SENHA_W-1:0] oper_value,
  output logic               oper_valid,
  output logic [SENHA_W-1:0] setup_value,
  output logic               setup_valid,
  output logic               setup_on,
  output logic               setup_abort,
  input  logic               setup_display_en,
  input  logic [BCD_W-1:0]   setup_bcd,
  input  logic [BCD_W-1:0]   oper_bcd,
  output logic [BCD_W-1:0]   bcd_out,
  input  logic [CFG_W-1:0]   setup_data_new,
  input  logic               setup_data_ok,
  output logic [CFG_W-1:0]   cfg_active,
  output logic               cfg_update,
  output logic               mode
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam int ON_W  = (SETUP_ON_CYC > 1) ? $clog2(SETUP_ON_CYC) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [ON_W-1:0]  ON_LAST = ON_W'(SETUP_ON_CYC - 1);

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_OPER   = 3'd1,
    ST_ENTER  = 3'd2,
    ST_SETUP  = 3'd3,
    ST_COMMIT = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [ON_W-1:0]    on_cnt_q, on_cnt_d;
  logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic               disp_en_q;
  logic               disp_fall_s;
  logic [SENHA_W-1:0] oper_value_q, oper_value_d;
  logic               oper_valid_q, oper_valid_d;
  logic [SENHA_W-1:0] setup_value_q, setup_value_d;
  logic               setup_valid_q, setup_valid_d;
  logic               setup_on_q, setup_on_d;
  logic               setup_abort_q, setup_abort_d;
  logic [CFG_W-1:0]   cfg_active_q, cfg_active_d;
  logic               cfg_update_q, cfg_update_d;
  logic               mode_q, mode_d;

  assign disp_fall_s = disp_en_q & ~setup_display_en;

  // Next-state logic, sequencing counters, commit/abort strobes and mode decode
  always_comb begin
    state_d       = state_q;
    on_cnt_d      = on_cnt_q;
    idle_cnt_d    = '0;
    setup_abort_d = 1'b0;
    cfg_update_d  = 1'b0;
    cfg_active_d  = cfg_active_q;
    case (state_q)
      ST_INIT: begin
        cfg_active_d = setup_data_new;
        cfg_update_d = 1'b1;
        state_d      = ST_OPER;
      end
      ST_OPER: begin
        if (setup_req) begin
          state_d  = ST_ENTER;
          on_cnt_d = '0;
        end else begin
          state_d  = ST_OPER;
        end
      end
      ST_ENTER: begin
        if (on_cnt_q == ON_LAST) begin
          state_d  = ST_SETUP;
          on_cnt_d = '0;
        end else begin
          on_cnt_d = on_cnt_q + ON_W'(1);
        end
      end
      ST_SETUP: begin
        // Inactivity counter saturates rather than wrapping
        if (key_valid) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q != {CNT_W{1'b1}}) begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end else begin
          idle_cnt_d = idle_cnt_q;
        end
        if (setup_data_ok) begin
          state_d      = ST_COMMIT;
          cfg_active_d = setup_data_new;
          cfg_update_d = 1'b1;
        end else if (disp_fall_s) begin
          state_d = ST_OPER;
        end else if (!key_valid && (idle_cnt_q == TO_LAST)) begin
          state_d       = ST_OPER;
          setup_abort_d = 1'b1;
        end else begin
          state_d = ST_SETUP;
        end
      end
      ST_COMMIT: begin
        state_d = ST_OPER;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
    setup_on_d = (state_d == ST_ENTER);
    mode_d     = (state_d == ST_ENTER) || (state_d == ST_SETUP) || (state_d == ST_COMMIT);
  end

  // Key routing: the side is chosen by the state in the cycle the key arrives
  always_comb begin
    oper_valid_d  = 1'b0;
    oper_value_d  = oper_value_q;
    setup_valid_d = 1'b0;
    setup_value_d = setup_value_q;
    if (key_valid && (state_q == ST_OPER)) begin
      oper_valid_d = 1'b1;
      oper_value_d = key_value;
    end else if (key_valid && (state_q == ST_SETUP)) begin
      setup_valid_d = 1'b1;
      setup_value_d = key_value;
    end else begin
      oper_valid_d  = 1'b0;
      setup_valid_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_INIT;
      on_cnt_q      <= '0;
      idle_cnt_q    <= '0;
      disp_en_q     <= 1'b0;
      oper_value_q  <= '1;
      oper_valid_q  <= 1'b0;
      setup_value_q <= '1;
      setup_valid_q <= 1'b0;
      setup_on_q    <= 1'b0;
      setup_abort_q <= 1'b0;
      cfg_active_q  <= '0;
      cfg_update_q  <= 1'b0;
      mode_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      on_cnt_q      <= on_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      disp_en_q     <= setup_display_en;
      oper_value_q  <= oper_value_d;
      oper_valid_q  <= oper_valid_d;
      setup_value_q <= setup_value_d;
      setup_valid_q <= setup_valid_d;
      setup_on_q    <= setup_on_d;
      setup_abort_q <= setup_abort_d;
      cfg_active_q  <= cfg_active_d;
      cfg_update_q  <= cfg_update_d;
      mode_q        <= mode_d;
    end
  end

  assign oper_value  = oper_value_q;
  assign oper_valid  = oper_valid_q;
  assign setup_value = setup_value_q;
  assign setup_valid = setup_valid_q;
  assign setup_on    = setup_on_q;
  assign setup_abort = setup_abort_q;
  assign cfg_active  = cfg_active_q;
  assign cfg_update  = cfg_update_q;
  assign mode        = mode_q;
  assign bcd_out     = (mode_q && setup_display_en) ? setup_bcd : oper_bcd;

endmodule

// File: tb/tb_fechadura_mode_ctrl.sv
// Directed self-checking bench for fechadura_mode_ctrl.
module tb_fechadura_mode_ctrl;

  localparam int SETUP_ON_CYC = 2;
  localparam int TIMEOUT_CYC  = 5000;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key_value;
  logic        key_valid;
  logic        setup_req;
  logic [3:0]  oper_value;
  logic        oper_valid;
  logic [3:0]  setup_value;
  logic        setup_valid;
  logic        setup_on;
  logic        setup_abort;
  logic        setup_display_en;
  logic [23:0] setup_bcd;
  logic [23:0] oper_bcd;
  logic [23:0] bcd_out;
  logic [31:0] setup_data_new;
  logic        setup_data_ok;
  logic [31:0] cfg_active;
  logic        cfg_update;
  logic        mode;

  int n_checks = 0;
  int n_fail   = 0;

  fechadura_mode_ctrl #(
    .SETUP_ON_CYC(SETUP_ON_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .SENHA_W     (4),
    .BCD_W       (24),
    .CFG_W       (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .key_value       (key_value),
    .key_valid       (key_valid),
    .setup_req       (setup_req),
    .oper_value      (oper_value),
    .oper_valid      (oper_valid),
    .setup_value     (setup_value),
    .setup_valid     (setup_valid),
    .setup_on        (setup_on),
    .setup_abort     (setup_abort),
    .setup_display_en(setup_display_en),
    .setup_bcd       (setup_bcd),
    .oper_bcd        (oper_bcd),
    .bcd_out         (bcd_out),
    .setup_data_new  (setup_data_new),
    .setup_data_ok   (setup_data_ok),
    .cfg_active      (cfg_active),
    .cfg_update      (cfg_update),
    .mode            (mode)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic enter_setup();
    setup_req = 1'b1;
    cyc();
    setup_req = 1'b0;
    repeat (SETUP_ON_CYC) cyc();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (10) cyc();
    n_checks++; if (mode !== 1'b0) begin $display("FAIL rst_mode: got %b exp 0", mode); n_fail++; end
    n_checks++; if (cfg_update !== 1'b0) begin $display("FAIL rst_cfg_update: got %b exp 0", cfg_update); n_fail++; end
    n_checks++; if (cfg_active !== 32'h0) begin $display("FAIL rst_cfg_active: got %h exp 0", cfg_active); n_fail++; end
    n_checks++; if ({oper_valid, setup_valid, setup_on, setup_abort} !== 4'b0000) begin
      $display("FAIL rst_strobes: got %b exp 0000", {oper_valid, setup_valid, setup_on, setup_abort}); n_fail++; end
    n_checks++; if ({oper_value, setup_value} !== 8'hFF) begin
      $display("FAIL rst_values: got %h exp ff", {oper_value, setup_value}); n_fail++; end
    rst = 1'b1;
    cyc();
    n_checks++; if (cfg_update !== 1'b1) begin $display("FAIL init_cfg_update: got %b exp 1", cfg_update); n_fail++; end
    n_checks++; if (cfg_active !== 32'h1234_5678) begin $display("FAIL init_cfg_active: got %h exp 12345678", cfg_active); n_fail++; end
    n_checks++; if (mode !== 1'b0) begin $display("FAIL init_mode: got %b exp 0", mode); n_fail++; end
    cyc();
    n_checks++; if (cfg_update !== 1'b0) begin $display("FAIL init_update_pulse: got %b exp 0", cfg_update); n_fail++; end
  endtask

  task automatic test_oper_keys();
    logic [3:0] k;
    for (int i = 1; i <= 4; i++) begin
      k = 4'(i);
      key_value = k;
      key_valid = 1'b1;
      cyc();
      n_checks++; if (oper_valid !== 1'b1 || oper_value !== k) begin
        $display("FAIL oper_key%0d: got v=%b d=%h exp v=1 d=%h", i, oper_valid, oper_value, k); n_fail++; end
      n_checks++; if (setup_valid !== 1'b0 || setup_value !== 4'hF) begin
        $display("FAIL oper_key%0d_setup_side: got v=%b d=%h exp v=0 d=f", i, setup_valid, setup_value); n_fail++; end
    end
    key_valid = 1'b0;
    cyc();
    n_checks++; if (oper_valid !== 1'b0 || oper_value !== 4'h4) begin
      $display("FAIL oper_idle: got v=%b d=%h exp v=0 d=4", oper_valid, oper_value); n_fail++; end
  endtask

  task automatic test_enter();
    setup_display_en = 1'b1;
    #1;
    n_checks++; if (bcd_out !== 24'h111111) begin $display("FAIL bcd_oper: got %h exp 111111", bcd_out); n_fail++; end
    setup_req = 1'b1;
    key_value = 4'h7;
    key_valid = 1'b1;
    cyc();
    setup_req = 1'b0;
    n_checks++; if (setup_on !== 1'b1 || mode !== 1'b1) begin
      $display("FAIL enter_c1: got on=%b mode=%b exp 1 1", setup_on, mode); n_fail++; end
    n_checks++; if (oper_valid !== 1'b1 || oper_value !== 4'h7) begin
      $display("FAIL same_cycle_key: got v=%b d=%h exp v=1 d=7", oper_valid, oper_value); n_fail++; end
    key_value = 4'h9;
    cyc();
    key_valid = 1'b0;
    n_checks++; if (setup_on !== 1'b1 || oper_valid !== 1'b0 || setup_valid !== 1'b0) begin
      $display("FAIL enter_c2: got on=%b ov=%b sv=%b exp 1 0 0", setup_on, oper_valid, setup_valid); n_fail++; end
    cyc();
    n_checks++; if (setup_on !== 1'b0 || mode !== 1'b1 || setup_valid !== 1'b0) begin
      $display("FAIL enter_c3: got on=%b mode=%b sv=%b exp 0 1 0", setup_on, mode, setup_valid); n_fail++; end
    key_value = 4'hA;
    key_valid = 1'b1;
    #1;
    n_checks++; if (bcd_out !== 24'h222222) begin $display("FAIL bcd_setup: got %h exp 222222", bcd_out); n_fail++; end
    cyc();
    key_valid = 1'b0;
    n_checks++; if (setup_valid !== 1'b1 || setup_value !== 4'hA || oper_valid !== 1'b0) begin
      $display("FAIL setup_key: got sv=%b d=%h ov=%b exp 1 a 0", setup_valid, setup_value, oper_valid); n_fail++; end
  endtask

  task automatic test_commit();
    setup_data_new = 32'h5A5A_5A5A;
    setup_data_ok  = 1'b1;
    cyc();
    setup_data_ok  = 1'b0;
    n_checks++; if (cfg_active !== 32'h5A5A_5A5A || cfg_update !== 1'b1 || mode !== 1'b1) begin
      $display("FAIL commit: got cfg=%h upd=%b mode=%b exp 5a5a5a5a 1 1", cfg_active, cfg_update, mode); n_fail++; end
    cyc();
    n_checks++; if (cfg_update !== 1'b0 || mode !== 1'b0 || setup_abort !== 1'b0) begin
      $display("FAIL commit_after: got upd=%b mode=%b abort=%b exp 0 0 0", cfg_update, mode, setup_abort); n_fail++; end
    #1;
    n_checks++; if (bcd_out !== 24'h111111) begin $display("FAIL bcd_back: got %h exp 111111", bcd_out); n_fail++; end
  endtask

  task automatic test_timeout();
    int abort_at;
    int upd_cnt;
    abort_at = 0;
    upd_cnt  = 0;
    enter_setup();
    setup_data_new = 32'hDEAD_BEEF;
    for (int i = 1; i <= TIMEOUT_CYC + 100; i++) begin
      cyc();
      if (cfg_update === 1'b1) upd_cnt++;
      if (setup_abort === 1'b1) begin
        abort_at = i;
        break;
      end
    end
    n_checks++; if (abort_at != TIMEOUT_CYC) begin
      $display("FAIL timeout_cycle: got %0d exp %0d", abort_at, TIMEOUT_CYC); n_fail++; end
    n_checks++; if (mode !== 1'b0) begin $display("FAIL timeout_mode: got %b exp 0", mode); n_fail++; end
    cyc();
    n_checks++; if (setup_abort !== 1'b0) begin $display("FAIL abort_pulse: got %b exp 0", setup_abort); n_fail++; end
    n_checks++; if (cfg_active !== 32'h5A5A_5A5A || upd_cnt != 0) begin
      $display("FAIL timeout_nocommit: got cfg=%h upd=%0d exp 5a5a5a5a 0", cfg_active, upd_cnt); n_fail++; end
  endtask

  task automatic test_ok_vs_timeout();
    enter_setup();
    repeat (TIMEOUT_CYC - 1) cyc();
    setup_data_new = 32'hCAFE_0001;
    setup_data_ok  = 1'b1;
    cyc();
    setup_data_ok  = 1'b0;
    n_checks++; if (cfg_update !== 1'b1 || cfg_active !== 32'hCAFE_0001 || setup_abort !== 1'b0) begin
      $display("FAIL ok_beats_timeout: got upd=%b cfg=%h abort=%b exp 1 cafe0001 0", cfg_update, cfg_active, setup_abort); n_fail++; end
    cyc();
    n_checks++; if (mode !== 1'b0 || setup_abort !== 1'b0) begin
      $display("FAIL ok_beats_timeout_after: got mode=%b abort=%b exp 0 0", mode, setup_abort); n_fail++; end
  endtask

  task automatic test_disp_fall();
    enter_setup();
    setup_data_new   = 32'h0BAD_0BAD;
    setup_display_en = 1'b0;
    cyc();
    n_checks++; if (mode !== 1'b0 || cfg_update !== 1'b0 || setup_abort !== 1'b0 || cfg_active !== 32'hCAFE_0001) begin
      $display("FAIL disp_fall: got mode=%b upd=%b abort=%b cfg=%h exp 0 0 0 cafe0001", mode, cfg_update, setup_abort, cfg_active); n_fail++; end
    key_value = 4'h3;
    key_valid = 1'b1;
    cyc();
    key_valid = 1'b0;
    setup_display_en = 1'b1;
    n_checks++; if (oper_valid !== 1'b1 || oper_value !== 4'h3 || setup_valid !== 1'b0) begin
      $display("FAIL disp_fall_key: got ov=%b d=%h sv=%b exp 1 3 0", oper_valid, oper_value, setup_valid); n_fail++; end
  endtask

  task automatic test_reset_mid_enter();
    cyc();
    setup_req = 1'b1;
    cyc();
    setup_req = 1'b0;
    n_checks++; if (setup_on !== 1'b1) begin $display("FAIL midreset_pre: got %b exp 1", setup_on); n_fail++; end
    #1 rst = 1'b0;
    #1;
    n_checks++; if (setup_on !== 1'b0 || mode !== 1'b0 || cfg_active !== 32'h0) begin
      $display("FAIL midreset_async: got on=%b mode=%b cfg=%h exp 0 0 0", setup_on, mode, cfg_active); n_fail++; end
    cyc();
    cyc();
    setup_data_new = 32'h7777_0000;
    rst = 1'b1;
    cyc();
    n_checks++; if (cfg_update !== 1'b1 || cfg_active !== 32'h7777_0000 || mode !== 1'b0 || setup_on !== 1'b0) begin
      $display("FAIL midreset_init: got upd=%b cfg=%h mode=%b on=%b exp 1 77770000 0 0", cfg_update, cfg_active, mode, setup_on); n_fail++; end
  endtask

  initial begin
    rst              = 1'b0;
    key_value        = 4'h0;
    key_valid        = 1'b0;
    setup_req        = 1'b0;
    setup_display_en = 1'b0;
    setup_bcd        = 24'h222222;
    oper_bcd         = 24'h111111;
    setup_data_new   = 32'h1234_5678;
    setup_data_ok    = 1'b0;
    test_reset();
    test_oper_keys();
    test_enter();
    test_commit();
    test_timeout();
    test_ok_vs_timeout();
    test_disp_fall();
    test_reset_mid_enter();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fechadura_mode_ctrl.md
# fechadura_mode_ctrl

Mode controller for the lock: owns the keypad packet stream and the 7-segment BCD bus, and shares them between the operational block and the `setup` block. It sequences entry into setup by pulsing `setup_on`, enforces an inactivity timeout, commits the new configuration on `data_setup_ok`, and distributes the active configuration to the operational side. It sits between the keypad decoder, the operational/setup blocks and the display driver.

## Interface
- `SETUP_ON_CYC`, 2: cycles `setup_on` is held high on setup entry (≥1).
- `TIMEOUT_CYC`, 5000: clock cycles without `key_valid` in SETUP before abort (≥2).
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `key_value`  in  senhaPac_t  digit packet from keypad decoder.
- `key_valid`  in  1  one-cycle strobe qualifying `key_value`.
- `setup_req`  in  1  level from operational block: master PIN accepted, enter setup.
- `oper_value` / `oper_valid`  out  senhaPac_t / 1  packet routed to operational block.
- `setup_value` / `setup_valid`  out  senhaPac_t / 1  packet routed to setup block.
- `setup_on`  out  1  setup entry pulse to setup block.
- `setup_abort`  out  1  one-cycle pulse forcing setup block back to idle.
- `setup_display_en`  in  1  setup block owns display.
- `setup_bcd` / `oper_bcd`  in  bcdPac_t  BCD packets from each block.
- `bcd_out`  out  bcdPac_t  packet to display driver.
- `setup_data_new`  in  setupPac_t  configuration from setup block.
- `setup_data_ok`  in  1  one-cycle strobe: `setup_data_new` valid, commit.
- `cfg_active`  out  setupPac_t  configuration in force for operational block.
- `cfg_update`  out  1  one-cycle pulse when `cfg_active` changes.
- `mode`  out  1  0 = operational, 1 = setup path active.

## Operation
- States: INIT, OPER, ENTER, SETUP, COMMIT.
- INIT (first cycle after reset release): `cfg_active <= setup_data_new` (setup block's reset defaults), `cfg_update` pulses, -> OPER.
- OPER: keys routed to operational side; `setup_req`=1 -> ENTER. `setup_req` ignored in every other state.
- ENTER: `setup_on`=1 for exactly `SETUP_ON_CYC` cycles, then -> SETUP. Keys arriving in ENTER, INIT, COMMIT are dropped (no valid on either output).
- SETUP: keys routed to setup side; inactivity counter cleared on every `key_valid`, incremented otherwise.
  - `setup_data_ok`=1 -> COMMIT.
  - `setup_display_en` falling edge (1->0) without `setup_data_ok` -> OPER, no commit.
  - counter reaches `TIMEOUT_CYC`-1 -> `setup_abort` pulse, -> OPER, no commit.
  - priority same cycle: `setup_data_ok` > display_en fall > timeout.
- COMMIT (1 cycle): `cfg_active <= setup_data_new` (value sampled in the `setup_data_ok` cycle), `cfg_update`=1, -> OPER.
- `bcd_out` = `setup_bcd` when `mode`=1 and `setup_display_en`=1, else `oper_bcd` (combinational mux).
- `mode`=1 in ENTER, SETUP, COMMIT; 0 in INIT, OPER.
- Counter width `$clog2(TIMEOUT_CYC)`; saturates, never wraps.

## Timing
- Reset values: state INIT, `oper_valid`/`setup_valid`/`setup_on`/`setup_abort`/`cfg_update`/`mode` = 0, `oper_value`/`setup_value` = all ones, `cfg_active` = '0, counter 0.
- Key routing registered: `key_valid` at cycle N -> exactly one valid pulse at N+1 on the side selected by the state at N; value registered with it; other side valid=0, value unchanged.
- `key_valid` and `setup_req` in the same OPER cycle: key goes to operational side, then ENTER.
- `setup_req` at cycle N -> `setup_on` high N+1..N+SETUP_ON_CYC, `mode`=1 from N+1; first key accepted for setup side in cycle N+SETUP_ON_CYC+1.
- `setup_data_ok` at N -> `cfg_active`, `cfg_update` at N+1 (COMMIT output), `mode`=0 at N+2.
- Reset asserted mid-operation: all outputs return to reset values asynchronously; INIT re-runs after release; no partial commit.

## Test plan
- Reset 10 cycles, release -> `cfg_update` one pulse, `cfg_active` == `setup_data_new`, `mode`=0.
- OPER, keys 1,2,3,4 -> four `oper_valid` pulses, one cycle late, `setup_valid` stays 0.
- `setup_req`=1 -> `setup_on` high exactly 2 cycles, `mode`=1; key 'A' -> `setup_valid` pulse, `bcd_out` follows `setup_bcd` while `setup_display_en`=1.
- In SETUP drive `setup_data_new`=0x5A.., `setup_data_ok` pulse -> `cfg_active`=0x5A.. next cycle, one `cfg_update`, `mode`=0 after.
- In SETUP no keys for 5000 cycles -> `setup_abort` single pulse at cycle 5000, `cfg_active` unchanged, `cfg_update` never; same-cycle `setup_data_ok` instead commits.
- `setup_display_en` 1->0 without ok -> OPER, no commit; `rst` pulsed low mid-ENTER -> `setup_on` drops immediately, INIT reruns.
